// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Round-robin arbiter that shares the single byte-write port of the Ethernet
// session buffer between NREQ message sources. One source owns the port for a
// whole message. The message is framed by the o_wr envelope: one OPEN cycle
// before the first byte, and one CLOSE cycle with o_wr low afterwards so the
// session flushes its trailing partial PDU. Bytes pass through combinationally
// under i_full backpressure. A stalled owner is aborted after TIMEOUT idle
// cycles, and a runaway message is cut after MAX_BYTES bytes.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_req[k]        source k holds this high for its whole message
//   i_valid[k]      source k presents a byte
//   i_data[8k+:8]   byte of source k
//   o_gnt           one-hot grant (registered)
//   o_ready[k]      the port accepts source k's byte this cycle (combinational)
//   o_wr            session write envelope (to i_wr)
//   o_din           session byte strobe (to i_din)
//   o_data          session byte (to i_data); holds the last forwarded byte
//   i_full          session buffer full (from o_full)
//   o_busy          a message is in progress
//   o_abort         one-cycle pulse: the timeout revoked the grant
//   o_trunc         one-cycle pulse: MAX_BYTES forced the message closed
module eth_tx_arbiter #(
  parameter int          NREQ      = 2,
  parameter logic [15:0] TIMEOUT   = 16'd4096,
  parameter logic [15:0] MAX_BYTES = 16'd65535
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_valid,
  input  logic [8*NREQ-1:0] i_data,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_ready,
  output logic              o_wr,
  output logic              o_din,
  output logic [7:0]        o_data,
  input  logic              i_full,
  output logic              o_busy,
  output logic              o_abort,
  output logic              o_trunc
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_XFER  = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [15:0]     r_byte_cnt;
  logic [15:0]     r_idle_cnt;
  logic [7:0]      r_data;

  logic [PW-1:0]   w_pick;
  logic [NREQ-1:0] w_pick_oh;
  logic            w_own_req;
  logic            w_own_valid;
  logic [7:0]      w_own_byte;
  logic            w_own_ready;
  logic            w_accept;
  logic            w_hit_max;
  logic            w_hit_timeout;

  // First requester at or after the round-robin pointer, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Owner-side views and accept/exit conditions.
  always_comb begin
    w_pick      = rr_pick(i_req, r_rr_ptr);
    w_pick_oh   = '0;
    w_pick_oh[w_pick] = 1'b1;
    w_own_req   = i_req[r_owner];
    w_own_valid = i_valid[r_owner];
    w_own_byte  = i_data[{r_owner, 3'b000} +: 8];
    // A dropped request masks ready, so a byte offered with the drop is ignored.
    w_own_ready = (r_state == S_XFER) && w_own_req && !i_full;
    w_accept    = w_own_ready && w_own_valid;
    // 17-bit compare so a saturated count cannot wrap past the limit.
    w_hit_max   = w_accept && (({1'b0, r_byte_cnt} + 17'd1) >= {1'b0, MAX_BYTES});
    // An accept in the same cycle resets the idle count, so it cannot time out.
    w_hit_timeout = !w_accept && (r_idle_cnt >= TIMEOUT);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; exit priority in XFER is req drop, MAX_BYTES, TIMEOUT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_next_state = S_OPEN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_OPEN: w_next_state = S_XFER;
      S_XFER: begin
        if (!w_own_req || w_hit_max || w_hit_timeout) begin
          w_next_state = S_CLOSE;
        end else begin
          w_next_state = S_XFER;
        end
      end
      S_CLOSE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Owner, grant, round-robin pointer, counters and held output byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_byte_cnt <= 16'd0;
      r_idle_cnt <= 16'd0;
      r_data     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_owner <= w_pick;
            r_gnt   <= w_pick_oh;
          end
        end
        S_OPEN: begin
          r_byte_cnt <= 16'd0;
          r_idle_cnt <= 16'd0;
        end
        S_XFER: begin
          if (w_accept) begin
            r_data     <= w_own_byte;
            r_idle_cnt <= 16'd0;
            if (r_byte_cnt != 16'hFFFF) begin
              r_byte_cnt <= r_byte_cnt + 16'd1;
            end
          end else if (r_idle_cnt != 16'hFFFF) begin
            // Full-buffer stalls count as idle too.
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
          if (w_next_state == S_CLOSE) begin
            r_gnt <= '0;
          end
        end
        S_CLOSE: begin
          if (r_owner == PW'(NREQ - 1)) begin
            r_rr_ptr <= '0;
          end else begin
            r_rr_ptr <= r_owner + PW'(1);
          end
        end
        default: begin
          r_gnt <= '0;
        end
      endcase
    end
  end

  // Output decode.
  always_comb begin
    o_gnt   = r_gnt;
    o_ready = '0;
    o_ready[r_owner] = w_own_ready;
    o_wr    = (r_state == S_OPEN) || (r_state == S_XFER);
    o_din   = w_accept;
    if (w_accept) begin
      o_data = w_own_byte;
    end else begin
      o_data = r_data;
    end
    o_busy  = (r_state != S_IDLE);
    o_trunc = (r_state == S_XFER) && w_own_req && w_hit_max;
    o_abort = (r_state == S_XFER) && w_own_req && !w_hit_max && w_hit_timeout;
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter (NREQ=2, TIMEOUT=16, MAX_BYTES=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge. Expected session bytes are queued in the order the arbiter must emit
// them and popped whenever o_din is seen.
module tb_eth_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  i_req;
  logic [1:0]  i_valid;
  logic [15:0] i_data;
  logic        i_full;
  logic [1:0]  o_gnt;
  logic [1:0]  o_ready;
  logic        o_wr;
  logic        o_din;
  logic [7:0]  o_data;
  logic        o_busy;
  logic        o_abort;
  logic        o_trunc;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.NREQ(2), .TIMEOUT(16'd16), .MAX_BYTES(16'd4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_valid(i_valid),
    .i_data(i_data), .o_gnt(o_gnt), .o_ready(o_ready), .o_wr(o_wr),
    .o_din(o_din), .o_data(o_data), .i_full(i_full), .o_busy(o_busy),
    .o_abort(o_abort), .o_trunc(o_trunc)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] valid;
    logic [7:0] d0;
    logic [1:0] gnt;
    logic [1:0] rdy;
    logic       wr;
    logic       din;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t tbl[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int din_cnt = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;
  int trunc_cnt = 0;
  int trunc_din = 0;
  int rise_cyc = 0;
  int base;
  int t0;
  logic trunc_with_din = 1'b0;
  logic [1:0] prev_gnt = 2'b00;

  logic [7:0] exp_q[$];
  int         gnt_log[$];

  // Source models: byte queues, message length, hold-request and valid enables.
  logic [7:0] sq[2][$];
  int         msg_len[2];
  int         sent[2];
  logic       hold[2];
  logic       en_valid[2];
  logic       acc[2];

  logic       drv_on;
  logic [1:0] m_req;
  logic [1:0] m_valid;
  logic [7:0] m_d0;
  logic [7:0] m_d1;
  logic       m_full;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic load_src(input int k, input logic [7:0] b0, input int n);
    for (int i = 0; i < n; i++) sq[k].push_back(8'(b0 + 8'(i)));
  endtask

  task automatic load_exp(input logic [7:0] b0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(b0 + 8'(i)));
  endtask

  task automatic drive();
    logic [1:0] r;
    logic [1:0] v;
    logic [7:0] d[2];
    i_full = m_full;
    for (int k = 0; k < 2; k++) begin
      if (drv_on && acc[k]) begin
        if (sq[k].size() > 0) void'(sq[k].pop_front());
        sent[k]++;
      end
      acc[k] = 1'b0;
      // After a full message the source drops its request for one cycle.
      if (msg_len[k] != 0 && sent[k] >= msg_len[k]) begin
        r[k] = 1'b0;
        sent[k] = 0;
      end else begin
        r[k] = (sq[k].size() > 0) || hold[k];
      end
      v[k] = r[k] && en_valid[k] && (sq[k].size() > 0);
      d[k] = v[k] ? sq[k][0] : 8'h00;
    end
    if (drv_on) begin
      i_req   = r;
      i_valid = v;
      i_data  = {d[1], d[0]};
    end else begin
      i_req   = m_req;
      i_valid = m_valid;
      i_data  = {m_d1, m_d0};
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (o_din) begin
      din_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %0h expected none (cycle %0d)", o_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_byte", {24'd0, o_data}, {24'd0, e});
      end
    end
    if (o_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (o_trunc) begin
      trunc_cnt++;
      trunc_din = din_cnt;
      trunc_with_din = o_din;
    end
    if (o_gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_log.push_back(int'(o_gnt[1]));
      rise_cyc = cyc;
    end
    prev_gnt = o_gnt;
    for (int k = 0; k < 2; k++) acc[k] = o_ready[k] & i_valid[k];
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic src_reset();
    for (int k = 0; k < 2; k++) begin
      sq[k].delete();
      msg_len[k] = 0;
      sent[k] = 0;
      hold[k] = 1'b0;
      en_valid[k] = 1'b1;
      acc[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_req = 2'b00; i_valid = 2'b00; i_data = 16'h0000; i_full = 1'b0;
    drv_on = 1'b0; m_req = 2'b00; m_valid = 2'b00; m_d0 = 8'h00; m_d1 = 8'hEE; m_full = 1'b0;
    src_reset();

    tbl[0] = '{2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{2'b01, 2'b01, 8'hA1, 2'b01, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{2'b01, 2'b01, 8'hA1, 2'b01, 2'b01, 1'b1, 1'b1, 8'hA1, 1'b1};
    tbl[3] = '{2'b01, 2'b01, 8'hA2, 2'b01, 2'b01, 1'b1, 1'b1, 8'hA2, 1'b1};
    tbl[4] = '{2'b01, 2'b01, 8'hA3, 2'b01, 2'b01, 1'b1, 1'b1, 8'hA3, 1'b1};
    tbl[5] = '{2'b00, 2'b01, 8'hA4, 2'b01, 2'b00, 1'b1, 1'b0, 8'hA3, 1'b1};
    tbl[6] = '{2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'hA3, 1'b1};
    tbl[7] = '{2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'hA3, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_gnt", o_gnt, 2'b00);
    chk("rst_ready", o_ready, 2'b00);
    chk("rst_wr", o_wr, 1'b0);
    chk("rst_din", o_din, 1'b0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_abort", o_abort, 1'b0);
    chk("rst_trunc", o_trunc, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single message from source 0, cycle by cycle.
    load_exp(8'hA1, 3);
    for (int i = 0; i < 8; i++) begin
      m_req = tbl[i].req;
      m_valid = tbl[i].valid;
      m_d0 = tbl[i].d0;
      cycle();
      chk($sformatf("vec%0d_gnt", i), o_gnt, tbl[i].gnt);
      chk($sformatf("vec%0d_ready", i), o_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_wr", i), o_wr, tbl[i].wr);
      chk($sformatf("vec%0d_din", i), o_din, tbl[i].din);
      chk($sformatf("vec%0d_data", i), o_data, tbl[i].data);
      chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
    end
    chk("single_pending", exp_q.size(), 0);

    // Backpressure: source 1 alone, buffer full for 5 cycles after the first byte.
    drv_on = 1'b1;
    src_reset();
    load_src(1, 8'h30, 3);
    msg_len[1] = 3;
    load_exp(8'h30, 3);
    base = din_cnt;
    for (int n = 0; n < 12 && din_cnt == base; n++) cycle();
    chk("bp_first_byte", din_cnt - base, 1);
    m_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("bp_stall_ready", o_ready, 2'b00);
      chk("bp_stall_din", o_din, 1'b0);
      chk("bp_stall_wr", o_wr, 1'b1);
    end
    m_full = 1'b0;
    for (int n = 0; n < 30 && (exp_q.size() != 0 || o_busy); n++) cycle();
    chk("bp_bytes", din_cnt - base, 3);
    chk("bp_pending", exp_q.size(), 0);

    // Round-robin: both sources, two-byte messages, pointer now at 0.
    src_reset();
    load_src(0, 8'h10, 4);
    load_src(1, 8'h20, 4);
    msg_len[0] = 2;
    msg_len[1] = 2;
    load_exp(8'h10, 2); load_exp(8'h20, 2); load_exp(8'h12, 2); load_exp(8'h22, 2);
    gnt_log.delete();
    for (int n = 0; n < 80 && (exp_q.size() != 0 || o_busy); n++) cycle();
    chk("rr_pending", exp_q.size(), 0);
    chk("rr_grants", gnt_log.size(), 4);
    for (int i = 0; i < gnt_log.size(); i++) chk($sformatf("rr_order%0d", i), gnt_log[i], i % 2);

    // Timeout: source 0 holds request without data, source 1 waits.
    src_reset();
    hold[0] = 1'b1;
    en_valid[0] = 1'b0;
    load_src(1, 8'h90, 2);
    msg_len[1] = 2;
    load_exp(8'h90, 2);
    gnt_log.delete();
    t0 = abort_cnt;
    for (int n = 0; n < 60 && abort_cnt == t0; n++) cycle();
    chk("to_abort_seen", abort_cnt - t0, 1);
    chk("to_abort_delay", abort_cyc - rise_cyc, 17);
    chk("to_first_owner", (gnt_log.size() > 0) ? gnt_log[0] : 9, 0);
    hold[0] = 1'b0;
    cycle();
    chk("to_close_wr", o_wr, 1'b0);
    chk("to_close_gnt", o_gnt, 2'b00);
    chk("to_abort_pulse", o_abort, 1'b0);
    for (int n = 0; n < 30 && (exp_q.size() != 0 || o_busy); n++) cycle();
    chk("to_grants", gnt_log.size(), 2);
    chk("to_next_owner", (gnt_log.size() > 1) ? gnt_log[1] : 9, 1);
    chk("to_pending", exp_q.size(), 0);

    // Truncation: source 0 streams 10 bytes, only 4 may pass.
    src_reset();
    load_src(0, 8'h40, 10);
    load_exp(8'h40, 4);
    base = din_cnt;
    t0 = trunc_cnt;
    for (int n = 0; n < 40 && trunc_cnt == t0; n++) cycle();
    chk("tr_seen", trunc_cnt - t0, 1);
    chk("tr_on_4th", trunc_din - base, 4);
    chk("tr_with_din", trunc_with_din, 1'b1);
    sq[0].delete();
    acc[0] = 1'b0;
    cycle();
    chk("tr_close_wr", o_wr, 1'b0);
    chk("tr_close_gnt", o_gnt, 2'b00);
    chk("tr_pulse", o_trunc, 1'b0);
    cycle();
    chk("tr_idle_busy", o_busy, 1'b0);
    chk("tr_bytes", din_cnt - base, 4);
    chk("tr_pending", exp_q.size(), 0);

    // Reset mid-XFER: source 1 owns (pointer 1), reset hits during byte 2.
    src_reset();
    load_src(0, 8'h50, 2);
    load_src(1, 8'h60, 3);
    load_exp(8'h60, 1);
    base = din_cnt;
    for (int n = 0; n < 20 && din_cnt == base; n++) cycle();
    chk("mr_first_byte", din_cnt - base, 1);
    @(posedge clk);
    #1;
    drive();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt", o_gnt, 2'b00);
    chk("mr_ready", o_ready, 2'b00);
    chk("mr_wr", o_wr, 1'b0);
    chk("mr_din", o_din, 1'b0);
    chk("mr_data", o_data, 8'h00);
    chk("mr_busy", o_busy, 1'b0);
    chk("mr_pending", exp_q.size(), 0);
    src_reset();
    load_src(0, 8'h70, 1);
    load_src(1, 8'h80, 1);
    msg_len[0] = 1;
    msg_len[1] = 1;
    load_exp(8'h70, 1);
    load_exp(8'h80, 1);
    gnt_log.delete();
    prev_gnt = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 40 && (exp_q.size() != 0 || o_busy); n++) cycle();
    chk("mr_grants", gnt_log.size(), 2);
    chk("mr_first_owner", (gnt_log.size() > 0) ? gnt_log[0] : 9, 0);
    chk("mr_second_owner", (gnt_log.size() > 1) ? gnt_log[1] : 9, 1);
    chk("mr_after_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Round-robin arbiter that shares the single byte-write port of the Ethernet session buffer (i_wr / i_din / i_data / o_full) between NREQ message sources, e.g. the waveform acquisition stream and the command-reply channel.
- Grants one source for a whole message, frames that message with the session's write-enable envelope, and forwards bytes losslessly under the buffer-full backpressure.
- Closes each message with a one-cycle write-enable gap, so the session flushes the trailing partial PDU.
- Guards against stalled sources with a timeout and against runaway messages with a byte limit.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 16'd4096, idle cycles in XFER with no accepted byte before the grant is revoked.
- MAX_BYTES, 16'd65535, maximum bytes per message before forced close.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NREQ  per-source message request; held high for the whole message.
- i_valid  in  NREQ  per-source byte strobe.
- i_data  in  8*NREQ  per-source byte; source k uses bits [8k+7:8k].
- o_gnt  out  NREQ  one-hot grant, registered.
- o_ready  out  NREQ  per-source byte-accept, combinational.
- o_wr  out  1  session write envelope (to i_wr).
- o_din  out  1  session byte strobe (to i_din).
- o_data  out  8  session byte (to i_data).
- i_full  in  1  session buffer full (from o_full).
- o_busy  out  1  a message is in progress (state != IDLE).
- o_abort  out  1  one-cycle pulse when a timeout revokes the grant.
- o_trunc  out  1  one-cycle pulse when MAX_BYTES forces a close.

Behaviour:
- Reset: state IDLE; o_gnt=0, o_wr=0, o_din=0, o_data=0, o_busy=0, o_abort=0, o_trunc=0; rr pointer=0; counters=0. Reset asserted mid-message abandons the message immediately; no flush cycle is produced.
- States: IDLE, OPEN, XFER, CLOSE.
- IDLE: if any i_req is high, pick the first requester at or after the rr pointer (modulo NREQ), latch owner, set o_gnt, then go to OPEN. The grant is visible the cycle after the request is sampled.
- OPEN: o_wr=1 for one cycle, no bytes accepted, then XFER.
- XFER: o_wr=1.
  - o_ready[owner] = i_req[owner] & !i_full; all other ready bits are 0.
  - A byte is accepted when o_ready[owner] & i_valid[owner].
  - o_din = accept and o_data = owner's byte, both combinational pass-through, so a byte is never dropped at PDU boundaries.
  - o_data holds its last value when nothing is accepted.
- XFER exits:
  - i_req[owner]=0: go to CLOSE; a valid byte in the same cycle is ignored.
  - Byte count reaches MAX_BYTES on an accept: that byte is forwarded, o_trunc pulses, go to CLOSE.
  - Idle counter reaches TIMEOUT: o_abort pulses, go to CLOSE.
  - Exit priority: req drop, then MAX_BYTES, then TIMEOUT.
- Idle counter: counts XFER cycles without an accept, clears on each accept. i_full stalls count as idle, so a permanently full buffer also times out.
- CLOSE: o_wr=0, o_gnt=0, o_ready=0 for exactly one cycle; rr pointer becomes owner+1 (wraps NREQ-1 to 0); then IDLE. Minimum inter-message gap on o_wr is 2 cycles (CLOSE + IDLE).
- A source whose grant was revoked may request again immediately; it competes under round-robin.
- A request withdrawn before the grant is taken is harmless: the arbiter still goes through OPEN/XFER and closes on the first XFER cycle without sending bytes.
- Width rules: byte and idle counters are 16 bits and saturate; MAX_BYTES=0 is illegal.

Test Plan:
- Single message: i_req[0] high, 3 bytes A1,A2,A3 with valid every cycle, then req drops.
  - o_gnt=01 one cycle after req; o_wr high 1 cycle before the first o_din.
  - o_din pulses 3 times with A1..A3; o_wr low exactly 1 cycle in CLOSE; o_busy falls after IDLE is re-entered.
- Round-robin: both sources request continuously, 2 bytes per message.
  - Grant order is 0,1,0,1.
  - No byte from the non-owner appears on o_data.
- Backpressure: i_full held high for 5 cycles mid-message with i_valid high.
  - o_ready[owner]=0 and o_din=0 during the stall.
  - Transfer resumes with no lost or duplicated bytes; byte count equals the bytes sent.
- Timeout: TIMEOUT=16, owner holds req with i_valid=0.
  - o_abort pulses 16 cycles after entering XFER; o_wr drops 1 cycle; the other pending source is granted next.
- Truncation: MAX_BYTES=4, source streams 10 bytes.
  - Exactly 4 o_din pulses; o_trunc pulses on the 4th; o_wr gap follows.
- Reset mid-XFER: assert i_rst_n=0 during byte 2.
  - All outputs 0 asynchronously; after release, source 0 has priority.
